// File: rtl/elevator_pkg.sv
// Shared types, constants and floor-selection helpers for the elevator call controller.
package elevator_pkg;

  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_W     = 2;
  localparam int CLK_W       = 4;
  localparam int DOOR_HOLD_S = 5;
  localparam int CLK_SAT     = 15;

  typedef logic [NUM_FLOORS-1:0] floor_mask_t;
  typedef logic [FLOOR_W-1:0]    floor_t;
  typedef logic [CLK_W-1:0]      sec_t;

  // next_stage encoding: {valid, floor[1:0]}
  localparam logic [2:0] NS_NONE  = 3'b000;
  localparam logic       NS_VALID = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_DOOR     = 2'd3
  } state_t;

  // One-hot mask for a single floor.
  function automatic floor_mask_t floor_bit(input floor_t f);
    floor_bit = floor_mask_t'(1) << f;
  endfunction

  // Floors strictly above pos.
  function automatic floor_mask_t above_mask(input floor_t pos);
    floor_mask_t m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(pos)) m[i] = 1'b1;
    end
    above_mask = m;
  endfunction

  // Floors strictly below pos.
  function automatic floor_mask_t below_mask(input floor_t pos);
    floor_mask_t m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(pos)) m[i] = 1'b1;
    end
    below_mask = m;
  endfunction

  // Nearest pending floor in the travel direction, else nearest in the
  // opposite direction, else NS_NONE. The current floor is never offered.
  function automatic logic [2:0] pick_next(input floor_mask_t pend,
                                           input floor_t      pos,
                                           input logic        dir_up);
    floor_mask_t up_m;
    floor_mask_t dn_m;
    logic [2:0]  up_pick;
    logic [2:0]  dn_pick;
    up_m    = pend & above_mask(pos);
    dn_m    = pend & below_mask(pos);
    up_pick = NS_NONE;
    dn_pick = NS_NONE;
    // Descending scan: the last hit is the lowest floor above.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (up_m[i]) up_pick = {NS_VALID, floor_t'(i)};
    end
    // Ascending scan: the last hit is the highest floor below.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (dn_m[i]) dn_pick = {NS_VALID, floor_t'(i)};
    end
    if (dir_up) pick_next = up_pick[2] ? up_pick : dn_pick;
    else        pick_next = dn_pick[2] ? dn_pick : up_pick;
  endfunction

endpackage

// File: rtl/elevator_sec_timer.sv
// Door-hold second counter with its reset_clock handshake.
module elevator_sec_timer
  import elevator_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick_1s,
  input  logic reset_clock,
  output sec_t actual_clock,
  output logic done_reset_clock
);

  // A request still high when reset releases must be seen low once before
  // it can be acknowledged again.
  logic armed;

  // Counter, acknowledge pulse and re-arm flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      actual_clock     <= '0;
      done_reset_clock <= 1'b0;
      armed            <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      armed            <= armed | ~reset_clock;
      done_reset_clock <= reset_clock & armed & ~done_reset_clock;
      if (reset_clock) begin
        actual_clock <= '0;
      end else if (tick_1s && (actual_clock != sec_t'(CLK_SAT))) begin
        actual_clock <= actual_clock + 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_ctrl.sv
// Elevator call controller: latches floor calls, dispatches the car, answers
// the car FSM handshakes and offers the next floor while the door is open.
module elevator_call_ctrl
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1s,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic                  STOP,
  input  logic                  Delay,
  input  logic                  FR_Delay,
  input  logic                  reset_clock,
  input  logic                  UD_Answer,
  input  logic [FLOOR_W-1:0]    Actual_Stage,
  input  logic [2:0]            Solicitud_stage,
  output logic [2:0]            next_stage,
  output logic                  OC_Request,
  output logic                  UD_Request,
  output logic                  NO_STOP,
  output logic                  DoneDelay,
  output logic                  DoneFRDelay,
  output logic                  DoneResetClock,
  output logic [CLK_W-1:0]      actual_clock,
  output logic [NUM_FLOORS-1:0] pending
);

  state_t      state, state_nxt;
  floor_t      position, target;
  logic        dir_up, target_valid;
  floor_mask_t btn_q;
  logic        delay_armed, fr_armed, fr_hold;

  floor_mask_t rise, pend_eff, clr_mask, pending_nxt;
  logic        delay_acc, fr_acc, arrive, idle_go, idle_up, door_leave;

  elevator_sec_timer u_sec_timer (
    .clk              (clk),
    .reset            (reset),
    .tick_1s          (tick_1s),
    .reset_clock      (reset_clock),
    .actual_clock     (actual_clock),
    .done_reset_clock (DoneResetClock)
  );

  assign rise      = call_btn & ~btn_q;
  // A call arriving on this edge already counts for the IDLE dispatch decision.
  assign pend_eff  = pending | rise;
  assign delay_acc = Delay & delay_armed & ~DoneDelay;
  assign fr_acc    = FR_Delay & fr_armed & ~DoneFRDelay;
  assign arrive    = delay_acc &
                     (pending[Actual_Stage] | (target_valid & (target == Actual_Stage)));
  assign idle_go   = STOP & (|(pend_eff & ~floor_bit(position)));
  assign idle_up   = |(pend_eff & above_mask(position));
  assign door_leave = target_valid & (actual_clock >= sec_t'(DOOR_HOLD_S));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt  = state;
    OC_Request = 1'b0;
    NO_STOP    = 1'b0;
    next_stage = NS_NONE;
    case (state)
      ST_IDLE: begin
        if (idle_go) state_nxt = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        NO_STOP = 1'b1;
        if (!STOP) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (STOP)        state_nxt = ST_IDLE;
        else if (arrive) state_nxt = ST_DOOR;
      end
      ST_DOOR: begin
        OC_Request = 1'b1;
        if (!fr_hold) next_stage = pick_next(pending, position, dir_up);
        if (STOP)            state_nxt = ST_IDLE;
        else if (door_leave) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Which pending bit is being served this cycle.
  always_comb begin
    clr_mask = '0;
    case (state)
      ST_IDLE: clr_mask = floor_bit(position);
      ST_RUN:  if (state_nxt == ST_DOOR) clr_mask = floor_bit(Actual_Stage);
      ST_DOOR: clr_mask = floor_bit(position);
      default: clr_mask = '0;
    endcase
    // With the door open at floor i a fresh call to i is already served, so
    // the clear wins there; everywhere else a new call must not be lost.
    if (state == ST_DOOR) pending_nxt = pend_eff & ~clr_mask;
    else                  pending_nxt = (pending & ~clr_mask) | rise;
  end

  // Call latching, handshake acknowledges and captured car context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q        <= '0;
      pending      <= '0;
      position     <= '0;
      dir_up       <= 1'b1;
      target       <= '0;
      target_valid <= 1'b0;
      UD_Request   <= 1'b0;
      DoneDelay    <= 1'b0;
      DoneFRDelay  <= 1'b0;
      delay_armed  <= 1'b0;
      fr_armed     <= 1'b0;
      fr_hold      <= 1'b0;
    end else begin
      btn_q       <= call_btn;
      pending     <= pending_nxt;
      delay_armed <= delay_armed | ~Delay;
      fr_armed    <= fr_armed | ~FR_Delay;
      DoneDelay   <= delay_acc;
      DoneFRDelay <= fr_acc;
      if (delay_acc) begin
        position <= Actual_Stage;
        dir_up   <= UD_Answer;
      end
      if ((state == ST_IDLE) && idle_go) UD_Request <= idle_up;
      if ((state == ST_RUN) && (state_nxt == ST_DOOR)) target_valid <= 1'b0;
      if (fr_acc && Solicitud_stage[2]) begin
        target       <= Solicitud_stage[FLOOR_W-1:0];
        target_valid <= 1'b1;
      end
      // Once the car FSM has taken an offer, stop offering until the door visit ends.
      fr_hold <= (state_nxt == ST_DOOR) & (fr_hold | ((state == ST_DOOR) & fr_acc));
    end
  end

endmodule

// File: tb/tb_elevator_call_ctrl.sv
// Directed bench for elevator_call_ctrl with hand-computed expectations.
module tb_elevator_call_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1s;
  logic [3:0] call_btn;
  logic       STOP, Delay, FR_Delay, reset_clock, UD_Answer;
  logic [1:0] Actual_Stage;
  logic [2:0] Solicitud_stage;
  logic [2:0] next_stage;
  logic       OC_Request, UD_Request, NO_STOP;
  logic       DoneDelay, DoneFRDelay, DoneResetClock;
  logic [3:0] actual_clock;
  logic [3:0] pending;

  int n_vec = 0;
  int n_mis = 0;

  elevator_call_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .tick_1s         (tick_1s),
    .call_btn        (call_btn),
    .STOP            (STOP),
    .Delay           (Delay),
    .FR_Delay        (FR_Delay),
    .reset_clock     (reset_clock),
    .UD_Answer       (UD_Answer),
    .Actual_Stage    (Actual_Stage),
    .Solicitud_stage (Solicitud_stage),
    .next_stage      (next_stage),
    .OC_Request      (OC_Request),
    .UD_Request      (UD_Request),
    .NO_STOP         (NO_STOP),
    .DoneDelay       (DoneDelay),
    .DoneFRDelay     (DoneFRDelay),
    .DoneResetClock  (DoneResetClock),
    .actual_clock    (actual_clock),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    all_outs = 32'({next_stage, OC_Request, UD_Request, NO_STOP, DoneDelay,
                    DoneFRDelay, DoneResetClock, actual_clock, pending});
  endfunction

  initial begin
    reset = 1'b0; tick_1s = 1'b0; call_btn = 4'b0000;
    STOP = 1'b0; Delay = 1'b0; FR_Delay = 1'b0; reset_clock = 1'b0;
    UD_Answer = 1'b0; Actual_Stage = 2'd0; Solicitud_stage = 3'b000;

    #1;
    check("reset_outputs", all_outs(), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_reset_pending", 32'(pending), 32'd0);
    check("post_reset_nostop", 32'(NO_STOP), 32'd0);

    // Call to floor 2 from floor 0 with STOP asserted.
    STOP = 1'b1; call_btn = 4'b0100;
    step();
    check("call2_pending", 32'(pending), 32'h4);
    check("call2_ud_up", 32'(UD_Request), 32'd1);
    check("call2_nostop", 32'(NO_STOP), 32'd1);
    call_btn = 4'b0000;
    step();
    check("dispatch_hold", 32'(NO_STOP), 32'd1);
    STOP = 1'b0;
    step();
    check("dispatch_release", 32'(NO_STOP), 32'd0);

    // Pass floor 1 without stopping.
    Delay = 1'b1; Actual_Stage = 2'd1; UD_Answer = 1'b1;
    step();
    check("pass1_done", 32'(DoneDelay), 32'd1);
    check("pass1_oc", 32'(OC_Request), 32'd0);
    check("pass1_pending", 32'(pending), 32'h4);
    Delay = 1'b0;
    step();
    check("pass1_done_drop", 32'(DoneDelay), 32'd0);

    // Arrive at floor 2.
    Delay = 1'b1; Actual_Stage = 2'd2;
    step();
    check("arr2_done", 32'(DoneDelay), 32'd1);
    check("arr2_pending", 32'(pending), 32'h0);
    check("arr2_oc", 32'(OC_Request), 32'd1);
    Delay = 1'b0;
    step();
    check("arr2_done_drop", 32'(DoneDelay), 32'd0);
    check("door_empty_next", 32'(next_stage), 32'h0);

    // Call to the floor the door is open at is absorbed.
    call_btn = 4'b0100;
    step();
    check("door_same_floor_clear", 32'(pending), 32'h0);
    call_btn = 4'b0000;

    // Call above, then one below: direction up keeps offering floor 3.
    call_btn = 4'b1000;
    step();
    check("call3_pending", 32'(pending), 32'h8);
    check("offer3", 32'(next_stage), 32'h7);
    call_btn = 4'b0001;
    step();
    check("offer3_dir_up", 32'(next_stage), 32'h7);
    call_btn = 4'b0000;

    // Door timer restart.
    reset_clock = 1'b1;
    step();
    check("rc_clock_zero", 32'(actual_clock), 32'd0);
    check("rc_done", 32'(DoneResetClock), 32'd1);
    reset_clock = 1'b0;
    step();
    check("rc_done_drop", 32'(DoneResetClock), 32'd0);

    // Car FSM accepts the offer for floor 3.
    FR_Delay = 1'b1; Solicitud_stage = 3'b111;
    step();
    check("fr_done", 32'(DoneFRDelay), 32'd1);
    check("fr_offer_cleared", 32'(next_stage), 32'h0);
    FR_Delay = 1'b0; Solicitud_stage = 3'b000;
    step();
    check("fr_done_drop", 32'(DoneFRDelay), 32'd0);
    check("fr_offer_held", 32'(next_stage), 32'h0);

    // Door holds until 5 s have elapsed.
    tick_1s = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    tick_1s = 1'b0;
    check("hold_clock5", 32'(actual_clock), 32'd5);
    check("hold_oc_still_open", 32'(OC_Request), 32'd1);
    step();
    check("door_close_oc", 32'(OC_Request), 32'd0);
    check("door_close_clock", 32'(actual_clock), 32'd5);

    // Arrive at floor 3 (pending and target), then direction-up with only floors below.
    Delay = 1'b1; Actual_Stage = 2'd3; UD_Answer = 1'b1;
    step();
    check("arr3_oc", 32'(OC_Request), 32'd1);
    check("arr3_pending", 32'(pending), 32'h1);
    Delay = 1'b0;
    check("offer0_opposite", 32'(next_stage), 32'h4);
    call_btn = 4'b0010;
    step();
    call_btn = 4'b0000;
    check("offer1_nearest_below", 32'(next_stage), 32'h5);
    check("door_stays_open", 32'(OC_Request), 32'd1);

    // STOP in DOOR returns to IDLE, then dispatch downward.
    STOP = 1'b1;
    step();
    check("stop_door_oc", 32'(OC_Request), 32'd0);
    check("stop_door_nostop", 32'(NO_STOP), 32'd0);
    step();
    check("idle_dispatch_nostop", 32'(NO_STOP), 32'd1);
    check("idle_dispatch_down", 32'(UD_Request), 32'd0);
    STOP = 1'b0;
    step();

    // Arrive at floor 1 going down; down direction prefers floor 0 over 3.
    Delay = 1'b1; Actual_Stage = 2'd1; UD_Answer = 1'b0;
    step();
    Delay = 1'b0;
    check("arr1_pending", 32'(pending), 32'h1);
    check("offer0_dir_down", 32'(next_stage), 32'h4);
    call_btn = 4'b1000;
    step();
    call_btn = 4'b0000;
    check("offer0_down_pref", 32'(next_stage), 32'h4);

    // Simultaneous Delay and FR_Delay, held two cycles.
    Delay = 1'b1; FR_Delay = 1'b1; Actual_Stage = 2'd1; Solicitud_stage = 3'b000;
    step();
    check("dual_delay_ack", 32'(DoneDelay), 32'd1);
    check("dual_fr_ack", 32'(DoneFRDelay), 32'd1);
    step();
    check("dual_no_repeat", 32'({DoneDelay, DoneFRDelay}), 32'd0);
    Delay = 1'b0; FR_Delay = 1'b0;
    step();

    // Counter saturation.
    reset_clock = 1'b1;
    step();
    check("sat_rc_done", 32'(DoneResetClock), 32'd1);
    check("sat_rc_zero", 32'(actual_clock), 32'd0);
    reset_clock = 1'b0;
    tick_1s = 1'b1;
    step();
    check("sat_done_drop", 32'(DoneResetClock), 32'd0);
    for (int i = 2; i <= 17; i++) step();
    tick_1s = 1'b0;
    check("sat_clock15", 32'(actual_clock), 32'd15);
    step();
    check("sat_clock15_held", 32'(actual_clock), 32'd15);

    // Reset in the middle of a Delay handshake.
    Delay = 1'b1; Actual_Stage = 2'd2;
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_ack_after_reset", 32'(DoneDelay), 32'd0);
    end
    Delay = 1'b0;
    step();
    Delay = 1'b1;
    step();
    check("new_delay_ack", 32'(DoneDelay), 32'd1);
    Delay = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/elevator_call_ctrl.md
ELEVATOR_CALL_CTRL -- requirements
Module: elevator_call_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; one clock, no other clock domain.
REQ-003 tick_1s  in  1  one-cycle 1 Hz enable strobe.
REQ-004 call_btn  in  4  per-floor call buttons (floors 0..3), level, unsynchronised edges already removed upstream.
REQ-005 STOP, Delay, FR_Delay, reset_clock, UD_Answer  in  1 each  status/handshake from car FSM.
REQ-006 Actual_Stage  in  2  car floor reported with Delay; Solicitud_stage  in  3  echo of accepted request.
REQ-007 next_stage  out  3  {valid, floor[1:0]}; 3'b000 = no request.
REQ-008 OC_Request, UD_Request, NO_STOP  out  1 each  door-open request, travel direction (1 = up), start command.
REQ-009 DoneDelay, DoneFRDelay, DoneResetClock  out  1 each  one-cycle acknowledges.
REQ-010 actual_clock  out  4  elapsed seconds since last reset_clock; pending  out  4  registered call bits.

Function
REQ-011 Rising edge of call_btn[i] SHALL set pending[i] next cycle.
REQ-012 Delay=1 while DoneDelay=0 SHALL produce DoneDelay=1 for exactly one cycle, one cycle later; position<=Actual_Stage, dir<=UD_Answer captured same edge.
REQ-013 FR_Delay=1 while DoneFRDelay=0 SHALL produce one-cycle DoneFRDelay next cycle; if Solicitud_stage[2]=1, target<=Solicitud_stage[1:0], target_valid<=1.
REQ-014 reset_clock=1 SHALL clear actual_clock to 0 and pulse DoneResetClock one cycle later; else tick_1s increments actual_clock, saturating at 15.
REQ-015 States: IDLE, DISPATCH, RUN, DOOR.
REQ-016 IDLE (NO_STOP=0, OC_Request=0): if STOP=1 and pending has bit != position, UD_Request<=(lowest such floor > position ? 1 : nearest-below rule), NO_STOP<=1, ->DISPATCH; pending[position] cleared without leaving IDLE.
REQ-017 DISPATCH: hold NO_STOP=1 until STOP=0 sampled, then NO_STOP<=0, ->RUN.
REQ-018 RUN (OC_Request=0): on Delay handshake, if pending[Actual_Stage] or (target_valid and target=Actual_Stage): clear that pending bit, target_valid<=0, ->DOOR; else remain (pass floor).
REQ-019 DOOR (OC_Request=1): next_stage SHALL offer nearest pending floor in dir, else nearest opposite, else 3'b000; after FR_Delay handshake next_stage<=0 until state exit.
REQ-020 DOOR: when target_valid=1 and actual_clock>=5, OC_Request<=0, ->RUN; STOP=1 observed in DOOR or RUN SHALL ->IDLE.
REQ-021 Simultaneous call_btn[i] edge and clear of bit i: clear wins only in DOOR at position i; otherwise set wins.
REQ-022 Simultaneous Delay and FR_Delay: both acknowledged same cycle.
REQ-023 Acknowledge outputs SHALL never be high two consecutive cycles.

Reset
REQ-024 reset=0 SHALL immediately force: state IDLE, all outputs 0, pending=0, position=0, dir=up, target_valid=0, actual_clock=0.
REQ-025 Reset asserted mid-handshake SHALL drop any Done* pulse; no acknowledge after release without new request.

Structure
REQ-026 elevator_pkg SHALL hold the state enum, NUM_FLOORS=4, DOOR_HOLD_S=5, CLK_SAT=15, next_stage encoding constants.
REQ-027 Second counter plus DoneResetClock logic SHALL be sub-module elevator_sec_timer.
REQ-028 Nearest-floor selection SHALL be combinational from pending, position, dir.

Verification
REQ-029 Reset release, call_btn[2] edge -> pending=4'b0100, UD_Request=1, NO_STOP=1 next cycle; STOP=0 -> NO_STOP=0.
REQ-030 RUN, Delay=1 with Actual_Stage=2 -> DoneDelay one cycle later, pending[2]=0, OC_Request=1.
REQ-031 DOOR, pending=4'b1000, pos=2 -> next_stage=3'b111; FR_Delay with Solicitud_stage=3'b111 -> DoneFRDelay, next_stage=0, OC_Request falls when actual_clock=5.
REQ-032 reset_clock pulse then 17 tick_1s -> DoneResetClock 1 cycle after reset_clock, actual_clock=15 held.
REQ-033 reset=0 during DoneDelay pending cycle -> all outputs 0 same instant; no DoneDelay after release.
